// File: rtl/can_pkg.sv
// Shared definitions for the CAN mailbox hub: frame geometry, TX FSM encoding
// and the identifier extraction helper.
package can_pkg;

    localparam int FRAME_W = 108;
    localparam int ID_W    = 11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    // The identifier sits in the top ID_W bits of a frame.
    function automatic logic [ID_W-1:0] frame_id(input logic [FRAME_W-1:0] frame);
        return ID_W'(frame >> (FRAME_W - ID_W));
    endfunction

endpackage

// File: rtl/can_rx_fifo.sv
// Show-ahead receive FIFO with occupancy count and a sticky overflow flag.
// Pointers wrap naturally because DEPTH is a power of two.
module can_rx_fifo #(
    parameter int W     = 108,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    input  logic          ovf_clr_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          full, do_pop, do_push, ovf_set;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || do_pop);
    assign ovf_set = push_i && full && !do_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_set)        ovf_q <= 1'b1;
            else if (ovf_clr_i) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/can_mailbox_hub.sv
// Transmit mailboxes sent lowest-ID-first to a can_controller, plus a buffered
// receive path fed by rising edges of the controller's rx_ready.
module can_mailbox_hub
    import can_pkg::*;
#(
    parameter int N_MBOX       = 4,
    parameter int RX_DEPTH     = 8,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IDX_W       = $clog2(N_MBOX),
    localparam int CNT_W       = $clog2(RX_DEPTH) + 1,
    localparam int TMO_W       = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic               GCLK,
    input  logic               RES,
    input  logic               mb_wr_en,
    input  logic [IDX_W-1:0]   mb_wr_idx,
    input  logic [FRAME_W-1:0] mb_wr_data,
    input  logic [N_MBOX-1:0]  mb_abort,
    output logic [N_MBOX-1:0]  mb_pending,
    output logic [N_MBOX-1:0]  mb_done,
    output logic [FRAME_W-1:0] ctl_din,
    output logic               ctl_tx_start,
    input  logic               ctl_tx_ready,
    input  logic               ctl_rx_ready,
    input  logic [FRAME_W-1:0] ctl_dout,
    input  logic               rx_rd_en,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_empty,
    output logic [CNT_W-1:0]   rx_count,
    output logic               rx_overflow,
    input  logic               rx_ovf_clr,
    output logic [1:0]         dbg_state_o
);

    logic [FRAME_W-1:0] frame_q [N_MBOX];
    logic [N_MBOX-1:0]  pending_q, pending_d, done_q;
    logic [N_MBOX-1:0]  wr_hit, active, cand;
    tx_state_e          state_q;
    logic [IDX_W-1:0]   sel_q, best_idx;
    logic [ID_W-1:0]    best_id;
    logic               best_found;
    logic [FRAME_W-1:0] din_q;
    logic               start_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               rx_prev_q;

    always_comb begin
        wr_hit = '0;
        active = '0;
        for (int i = 0; i < N_MBOX; i++) begin
            wr_hit[i] = mb_wr_en && (mb_wr_idx == IDX_W'(i));
            active[i] = (state_q != ST_IDLE) && (sel_q == IDX_W'(i));
        end
    end

    // Mailboxes being rewritten or cancelled this cycle sit out arbitration,
    // so the frame latched into ctl_din is always the one that ends up sent.
    assign cand = pending_q & ~mb_abort & ~wr_hit;

    always_comb begin
        best_found = 1'b0;
        best_idx   = '0;
        best_id    = '0;
        for (int i = 0; i < N_MBOX; i++) begin
            if (cand[i] && (!best_found || frame_id(frame_q[i]) < best_id)) begin
                best_found = 1'b1;
                best_idx   = IDX_W'(i);
                best_id    = frame_id(frame_q[i]);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_MBOX; i++) begin
            if (wr_hit[i] && !active[i])        pending_d[i] = 1'b1;
            else if (mb_abort[i] && !active[i]) pending_d[i] = 1'b0;
        end
        if (state_q == ST_WAIT_DONE && ctl_tx_ready) pending_d[sel_q] = 1'b0;
    end

    // Controller handshake: one tx_start strobe, then tx_ready must fall
    // (frame accepted) and rise again (frame finished) before completion.
    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < N_MBOX; i++) frame_q[i] <= '0;
            pending_q <= '0;
            done_q    <= '0;
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            din_q     <= '0;
            start_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            for (int i = 0; i < N_MBOX; i++) begin
                if (wr_hit[i] && !active[i]) frame_q[i] <= mb_wr_data;
            end
            pending_q <= pending_d;
            done_q    <= '0;
            start_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (best_found && ctl_tx_ready) begin
                        sel_q   <= best_idx;
                        din_q   <= frame_q[best_idx];
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    tmo_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!ctl_tx_ready) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (ctl_tx_ready) begin
                        done_q[sel_q] <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) rx_prev_q <= 1'b0;
        else     rx_prev_q <= ctl_rx_ready;
    end

    can_rx_fifo #(
        .W     (FRAME_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i      (GCLK),
        .rst_i      (RES),
        .push_i     (ctl_rx_ready && !rx_prev_q),
        .data_i     (ctl_dout),
        .pop_i      (rx_rd_en),
        .ovf_clr_i  (rx_ovf_clr),
        .data_o     (rx_data),
        .empty_o    (rx_empty),
        .count_o    (rx_count),
        .overflow_o (rx_overflow)
    );

    assign mb_pending   = pending_q;
    assign mb_done      = done_q;
    assign ctl_din      = din_q;
    assign ctl_tx_start = start_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_can_mailbox_hub.sv
// Bench for can_mailbox_hub: a behavioural controller model, arbitration vector
// table, directed corner sequences and a randomized RX FIFO scoreboard.
module tb_can_mailbox_hub;
    import can_pkg::*;

    localparam int N   = 4;
    localparam int D   = 8;
    localparam int TMO = 16;

    logic               GCLK = 1'b0;
    logic               RES  = 1'b1;
    logic               mb_wr_en = 1'b0;
    logic [1:0]         mb_wr_idx = '0;
    logic [FRAME_W-1:0] mb_wr_data = '0;
    logic [N-1:0]       mb_abort = '0;
    logic [N-1:0]       mb_pending, mb_done;
    logic [FRAME_W-1:0] ctl_din;
    logic               ctl_tx_start;
    logic               ctl_tx_ready = 1'b1;
    logic               ctl_rx_ready = 1'b0;
    logic [FRAME_W-1:0] ctl_dout = '0;
    logic               rx_rd_en = 1'b0;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_empty;
    logic [3:0]         rx_count;
    logic               rx_overflow;
    logic               rx_ovf_clr = 1'b0;
    logic [1:0]         dbg_state;

    can_mailbox_hub #(.N_MBOX(N), .RX_DEPTH(D), .BUSY_TIMEOUT(TMO)) dut (
        .GCLK(GCLK), .RES(RES),
        .mb_wr_en(mb_wr_en), .mb_wr_idx(mb_wr_idx), .mb_wr_data(mb_wr_data),
        .mb_abort(mb_abort), .mb_pending(mb_pending), .mb_done(mb_done),
        .ctl_din(ctl_din), .ctl_tx_start(ctl_tx_start), .ctl_tx_ready(ctl_tx_ready),
        .ctl_rx_ready(ctl_rx_ready), .ctl_dout(ctl_dout),
        .rx_rd_en(rx_rd_en), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_count(rx_count), .rx_overflow(rx_overflow), .rx_ovf_clr(rx_ovf_clr),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 GCLK = ~GCLK;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- controller model and monitors ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_left = 0;
    bit ctl_allow = 1'b1;
    bit ctl_stuck = 1'b0;
    logic [FRAME_W-1:0] tx_log[$];
    int                 tx_cyc[$];
    logic [N-1:0]       done_log[$];

    // Accepts a frame by dropping tx_ready for three cycles after tx_start.
    always @(posedge GCLK) begin
        #1;
        cyc++;
        if (RES) begin
            busy_left = 0;
        end else begin
            if (ctl_tx_start) begin
                tx_log.push_back(ctl_din);
                tx_cyc.push_back(cyc);
                if (!ctl_stuck) busy_left = 3;
            end
            if (mb_done != '0) done_log.push_back(mb_done);
        end
        if (busy_left > 0) begin
            ctl_tx_ready = 1'b0;
            busy_left--;
        end else begin
            ctl_tx_ready = ctl_allow;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge GCLK);
        #2;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic write_mb(input int idx, input logic [FRAME_W-1:0] f);
        mb_wr_en   = 1'b1;
        mb_wr_idx  = 2'(idx);
        mb_wr_data = f;
        tick();
        mb_wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int b = 0;
        while (done_log.size() < n && b < budget) begin
            tick();
            b++;
        end
        check(name, 128'(done_log.size() >= n), 128'(1));
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int b = 0;
        while (tx_log.size() < n && b < budget) begin
            tick();
            b++;
        end
        check(name, 128'(tx_log.size() >= n), 128'(1));
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        int b = 0;
        while (dbg_state != st && b < budget) begin
            tick();
            b++;
        end
        check(name, 128'(dbg_state), 128'(st));
    endtask

    function automatic logic [FRAME_W-1:0] mk(input logic [ID_W-1:0] id);
        return {id, 1'b0, $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- arbitration vector table ----------------
    typedef struct packed {
        logic [3:0]  mask;
        logic [43:0] ids;    // {mb3, mb2, mb1, mb0}
        logic [2:0]  n;
        logic [7:0]  order;  // 2-bit mailbox index per slot, first send in [1:0]
    } arb_vec_t;

    arb_vec_t vecs [5];
    logic [FRAME_W-1:0] fr [N];
    logic [ID_W-1:0]    ids [N];
    logic [FRAME_W-1:0] exp_q[$];

    initial begin
        int t0, d0, k, e;
        int ord [N];
        logic [N-1:0] mask, rem;
        logic [FRAME_W-1:0] rxf [9];
        bit m_prev, m_ovf, push, pop, ovf_new;

        vecs[0] = '{mask: 4'b0101, ids: {11'h000, 11'h045, 11'h000, 11'h123}, n: 3'd2, order: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[1] = '{mask: 4'b1010, ids: {11'h100, 11'h000, 11'h100, 11'h000}, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd1}};
        vecs[2] = '{mask: 4'b1111, ids: {11'h001, 11'h3AB, 11'h000, 11'h7FF}, n: 3'd4, order: {2'd0, 2'd2, 2'd3, 2'd1}};
        vecs[3] = '{mask: 4'b0100, ids: {11'h000, 11'h555, 11'h000, 11'h000}, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[4] = '{mask: 4'b1101, ids: {11'h00F, 11'h010, 11'h000, 11'h010}, n: 3'd3, order: {2'd0, 2'd2, 2'd0, 2'd3}};

        // ---- reset values, asynchronous and after release ----
        repeat (3) @(posedge GCLK);
        #2;
        check("rst_pending", 128'(mb_pending), 128'(0));
        check("rst_start", 128'(ctl_tx_start), 128'(0));
        RES = 1'b0;
        tick();
        check("rst_done", 128'(mb_done), 128'(0));
        check("rst_din", 128'(ctl_din), 128'(0));
        check("rst_empty", 128'(rx_empty), 128'(1));
        check("rst_count", 128'(rx_count), 128'(0));
        check("rst_ovf", 128'(rx_overflow), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(ST_IDLE));

        // ---- write-to-start latency ----
        fr[0] = mk(11'h2A5);
        d0 = done_log.size();
        write_mb(0, fr[0]);
        check("lat_pending", 128'(mb_pending), 128'(4'b0001));
        check("lat_start_n1", 128'(ctl_tx_start), 128'(0));
        tick();
        check("lat_start_n2", 128'(ctl_tx_start), 128'(1));
        check("lat_din", 128'(ctl_din), 128'(fr[0]));
        tick();
        check("lat_start_1cyc", 128'(ctl_tx_start), 128'(0));
        wait_done(d0 + 1, 50, "lat_done_wait");
        check("lat_done_idx", 128'(done_log[d0]), 128'(4'b0001));
        check("lat_din_hold", 128'(ctl_din), 128'(fr[0]));
        tick();

        // ---- table-driven arbitration order ----
        foreach (vecs[v]) begin
            ctl_allow = 1'b0;
            tick();
            tick();
            for (int i = 0; i < N; i++) begin
                if (vecs[v].mask[i]) begin
                    fr[i] = mk(vecs[v].ids[i*11 +: 11]);
                    write_mb(i, fr[i]);
                end
            end
            tick();
            check($sformatf("vec%0d_pending", v), 128'(mb_pending), 128'(vecs[v].mask));
            t0 = tx_log.size();
            d0 = done_log.size();
            ctl_allow = 1'b1;
            wait_done(d0 + int'(vecs[v].n), 200, $sformatf("vec%0d_wait", v));
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                e = int'(vecs[v].order[j*2 +: 2]);
                check($sformatf("vec%0d_frame%0d", v, j), 128'(tx_log[t0+j]), 128'(fr[e]));
                check($sformatf("vec%0d_done%0d", v, j), 128'(done_log[d0+j]), 128'(4'(1) << e));
            end
            tick();
            check($sformatf("vec%0d_clear", v), 128'(mb_pending), 128'(0));
        end

        // ---- abort before START: nothing sent ----
        ctl_allow = 1'b0;
        tick();
        tick();
        write_mb(1, mk(11'h111));
        check("abort_pend_set", 128'(mb_pending), 128'(4'b0010));
        mb_abort = 4'b0010;
        tick();
        mb_abort = '0;
        check("abort_pend_clr", 128'(mb_pending), 128'(0));
        t0 = tx_log.size();
        d0 = done_log.size();
        ctl_allow = 1'b1;
        repeat (6) tick();
        check("abort_no_start", 128'(tx_log.size()), 128'(t0));
        check("abort_no_done", 128'(done_log.size()), 128'(d0));

        // ---- abort and write of the active mailbox are ignored ----
        fr[1] = mk(11'h0AA);
        write_mb(1, fr[1]);
        wait_state(ST_WAIT_DONE, 20, "act_reach_wd");
        mb_abort = 4'b0010;
        tick();
        mb_abort = '0;
        check("act_abort_ign", 128'(mb_pending), 128'(4'b0010));
        write_mb(1, mk(11'h0BB));
        wait_done(d0 + 1, 20, "act_done_wait");
        check("act_done_idx", 128'(done_log[d0]), 128'(4'b0010));
        check("act_frame", 128'(tx_log[t0]), 128'(fr[1]));
        repeat (6) tick();
        check("act_write_drop", 128'(mb_pending), 128'(0));
        check("act_one_tx", 128'(tx_log.size()), 128'(t0 + 1));

        // ---- busy timeout: retry keeps mailbox pending ----
        ctl_stuck = 1'b1;
        t0 = tx_log.size();
        d0 = done_log.size();
        fr[0] = mk(11'h321);
        write_mb(0, fr[0]);
        wait_tx(t0 + 1, 10, "tmo_first_start");
        ctl_stuck = 1'b0;
        repeat (8) tick();
        check("tmo_still_pend", 128'(mb_pending), 128'(4'b0001));
        wait_tx(t0 + 2, 40, "tmo_retry_start");
        if (tx_log.size() >= t0 + 2) begin
            check("tmo_gap", 128'(tx_cyc[t0+1] - tx_cyc[t0]), 128'(TMO + 2));
            check("tmo_retry_frame", 128'(tx_log[t0+1]), 128'(fr[0]));
        end
        wait_done(d0 + 1, 20, "tmo_done_wait");
        tick();
        check("tmo_cleared", 128'(mb_pending), 128'(0));

        // ---- randomized arbitration against a sort model ----
        for (int r = 0; r < 6; r++) begin
            ctl_allow = 1'b0;
            tick();
            tick();
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    ids[i] = 11'($urandom_range(0, 7));
                    fr[i]  = mk(ids[i]);
                    write_mb(i, fr[i]);
                end
            end
            rem = mask;
            k = 0;
            while (rem != '0) begin
                e = -1;
                for (int i = 0; i < N; i++)
                    if (rem[i] && (e < 0 || ids[i] < ids[e])) e = i;
                ord[k] = e;
                rem[e] = 1'b0;
                k++;
            end
            t0 = tx_log.size();
            d0 = done_log.size();
            ctl_allow = 1'b1;
            wait_done(d0 + k, 300, $sformatf("rnd%0d_wait", r));
            for (int j = 0; j < k; j++) begin
                check($sformatf("rnd%0d_frame%0d", r, j), 128'(tx_log[t0+j]), 128'(fr[ord[j]]));
                check($sformatf("rnd%0d_done%0d", r, j), 128'(done_log[d0+j]), 128'(4'(1) << ord[j]));
            end
            tick();
        end

        // ---- RX: overflow on the ninth frame, ordered pops, clear ----
        for (int i = 0; i < 9; i++) begin
            rxf[i] = mk(11'(i + 1));
            ctl_dout = rxf[i];
            ctl_rx_ready = 1'b1;
            tick();
            if (i == 0) check("rx_latency", 128'(rx_empty), 128'(0));
            ctl_rx_ready = 1'b0;
            tick();
        end
        check("rx_full_count", 128'(rx_count), 128'(D));
        check("rx_ovf_set", 128'(rx_overflow), 128'(1));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rx_pop%0d", i), 128'(rx_data), 128'(rxf[i]));
            rx_rd_en = 1'b1;
            tick();
            rx_rd_en = 1'b0;
        end
        check("rx_drained", 128'(rx_empty), 128'(1));
        rx_rd_en = 1'b1;
        tick();
        rx_rd_en = 1'b0;
        check("rx_pop_empty", 128'(rx_count), 128'(0));
        check("rx_ovf_sticky", 128'(rx_overflow), 128'(1));
        rx_ovf_clr = 1'b1;
        tick();
        rx_ovf_clr = 1'b0;
        check("rx_ovf_clr", 128'(rx_overflow), 128'(0));

        // ---- RX: randomized traffic against a queue scoreboard ----
        exp_q = {};
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ctl_rx_ready = 1'($urandom_range(0, 1));
            ctl_dout     = mk(11'($urandom_range(0, 2047)));
            rx_rd_en     = ($urandom_range(0, 99) < ((c < 200) ? 12 : 55));
            rx_ovf_clr   = ($urandom_range(0, 99) < 6);
            push    = ctl_rx_ready && !m_prev;
            pop     = rx_rd_en && (exp_q.size() > 0);
            ovf_new = push && (exp_q.size() == D) && !pop;
            if (pop) void'(exp_q.pop_front());
            if (push && !ovf_new) exp_q.push_back(ctl_dout);
            if (ovf_new) m_ovf = 1'b1;
            else if (rx_ovf_clr) m_ovf = 1'b0;
            m_prev = ctl_rx_ready;
            tick();
            check("rxr_count", 128'(rx_count), 128'(exp_q.size()));
            check("rxr_ovf", 128'(rx_overflow), 128'(m_ovf));
            check("rxr_empty", 128'(rx_empty), 128'(exp_q.size() == 0));
            if (exp_q.size() > 0) check("rxr_data", 128'(rx_data), 128'(exp_q[0]));
        end
        ctl_rx_ready = 1'b0;
        rx_rd_en     = 1'b0;
        rx_ovf_clr   = 1'b0;
        tick();

        // ---- asynchronous reset during WAIT_DONE ----
        ctl_allow = 1'b1;
        write_mb(0, mk(11'h050));
        write_mb(1, mk(11'h060));
        wait_state(ST_WAIT_DONE, 30, "res_reach_wd");
        #3;
        RES = 1'b1;
        #1;
        check("res_pending", 128'(mb_pending), 128'(0));
        check("res_done", 128'(mb_done), 128'(0));
        check("res_din", 128'(ctl_din), 128'(0));
        check("res_start", 128'(ctl_tx_start), 128'(0));
        check("res_state", 128'(dbg_state), 128'(ST_IDLE));
        check("res_rx_count", 128'(rx_count), 128'(0));
        check("res_rx_empty", 128'(rx_empty), 128'(1));
        tick();
        RES = 1'b0;
        t0 = tx_log.size();
        repeat (8) tick();
        check("res_no_tx", 128'(tx_log.size()), 128'(t0));
        check("res_discard", 128'(mb_pending), 128'(0));

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
